// File: rtl/alarm_buzz_sequencer.sv
// alarm_buzz_sequencer
// Drives the buzzer_on / no_buzz levels of the tone stage from an alarm
// trigger and snooze/dismiss button requests. Once an alarm event starts it
// produces bursts of short beeps (BEEP/GAP), a longer PAUSE between bursts,
// and repeats until dismissed, snoozed (limited count) or the cumulative
// ringing time expires. All timing uses a tick prescaled from clk.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   alarm_trig   level from alarm compare; rising edge starts an event
//   snooze_req   debounced request; rising edge = one snooze request
//   dismiss_req  debounced request; rising edge = one dismiss request
//   buzzer_on    high while beeping
//   no_buzz      high when idle or snoozed
//   alarm_active high whenever an alarm event is in progress
//   snoozed      high while snoozed
//   snooze_cnt   snoozes used in the current event
module alarm_buzz_sequencer #(
  parameter int unsigned TICK_DIV        = 100000,
  parameter int unsigned BEEP_MS         = 100,
  parameter int unsigned GAP_MS          = 100,
  parameter int unsigned BEEPS_PER_BURST = 4,
  parameter int unsigned PAUSE_MS        = 600,
  parameter int unsigned SNOOZE_MS       = 300000,
  parameter int unsigned MAX_SNOOZES     = 3,
  parameter int unsigned RING_MS         = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_trig,
  input  logic       snooze_req,
  input  logic       dismiss_req,
  output logic       buzzer_on,
  output logic       no_buzz,
  output logic       alarm_active,
  output logic       snoozed,
  output logic [1:0] snooze_cnt
);

  localparam int unsigned MAX_BG    = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
  localparam int unsigned MAX_BGP   = (MAX_BG > PAUSE_MS) ? MAX_BG : PAUSE_MS;
  localparam int unsigned PHASE_MAX = (MAX_BGP > SNOOZE_MS) ? MAX_BGP : SNOOZE_MS;

  localparam int unsigned PRW = $clog2(TICK_DIV) + 1;
  localparam int unsigned PHW = $clog2(PHASE_MAX) + 1;
  localparam int unsigned RGW = $clog2(RING_MS) + 1;
  localparam int unsigned BIW = $clog2(BEEPS_PER_BURST) + 1;

  localparam logic [PRW-1:0] PRESC_LAST    = PRW'(TICK_DIV - 1);
  localparam logic [PHW-1:0] BEEP_LAST     = PHW'(BEEP_MS - 1);
  localparam logic [PHW-1:0] GAP_LAST      = PHW'(GAP_MS - 1);
  localparam logic [PHW-1:0] PAUSE_LAST    = PHW'(PAUSE_MS - 1);
  localparam logic [PHW-1:0] SNOOZE_LAST   = PHW'(SNOOZE_MS - 1);
  localparam logic [RGW-1:0] RING_LAST     = RGW'(RING_MS - 1);
  localparam logic [BIW-1:0] BEEP_IDX_LAST = BIW'(BEEPS_PER_BURST - 1);
  localparam logic [1:0]     SNOOZE_LIMIT  = 2'(MAX_SNOOZES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEEP,
    S_GAP,
    S_PAUSE,
    S_SNOOZE
  } state_t;

  state_t         state_q, state_d;
  logic [PRW-1:0] presc_q, presc_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [RGW-1:0] ring_q, ring_d;
  logic [BIW-1:0] beep_idx_q, beep_idx_d;
  logic [1:0]     snooze_cnt_q, snooze_cnt_d;

  logic alarm_trig_q, alarm_trig_d;
  logic snooze_req_q, snooze_req_d;
  logic dismiss_req_q, dismiss_req_d;

  logic buzzer_on_q, buzzer_on_d;
  logic no_buzz_q, no_buzz_d;
  logic alarm_active_q, alarm_active_d;
  logic snoozed_q, snoozed_d;

  logic           trig_rise, snooze_rise, dismiss_rise;
  logic           tick, ringing, timeout, phase_done;
  logic [PHW-1:0] phase_last;

  always_comb begin
    alarm_trig_d  = alarm_trig;
    snooze_req_d  = snooze_req;
    dismiss_req_d = dismiss_req;

    trig_rise    = alarm_trig  & ~alarm_trig_q;
    snooze_rise  = snooze_req  & ~snooze_req_q;
    dismiss_rise = dismiss_req & ~dismiss_req_q;

    tick    = (presc_q == PRESC_LAST);
    ringing = (state_q == S_BEEP) || (state_q == S_GAP) || (state_q == S_PAUSE);
    timeout = ringing && tick && (ring_q == RING_LAST);

    case (state_q)
      S_BEEP:   phase_last = BEEP_LAST;
      S_GAP:    phase_last = GAP_LAST;
      S_PAUSE:  phase_last = PAUSE_LAST;
      S_SNOOZE: phase_last = SNOOZE_LAST;
      default:  phase_last = '0;
    endcase
    phase_done = tick && (phase_q == phase_last);

    state_d      = state_q;
    presc_d      = tick ? '0 : presc_q + 1'b1;
    phase_d      = tick ? phase_q + 1'b1 : phase_q;
    ring_d       = (ringing && tick) ? ring_q + 1'b1 : ring_q;
    beep_idx_d   = beep_idx_q;
    snooze_cnt_d = snooze_cnt_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        phase_d = '0;
        if (trig_rise) begin
          state_d      = S_BEEP;
          beep_idx_d   = '0;
          ring_d       = '0;
          snooze_cnt_d = '0;
        end
      end
      S_BEEP, S_GAP, S_PAUSE: begin
        if (dismiss_rise || timeout) begin
          state_d = S_IDLE;
        end else if (snooze_rise && (snooze_cnt_q < SNOOZE_LIMIT)) begin
          state_d      = S_SNOOZE;
          snooze_cnt_d = snooze_cnt_q + 1'b1;
          ring_d       = '0;
        end else if (phase_done) begin
          if (state_q == S_BEEP) begin
            if (beep_idx_q == BEEP_IDX_LAST) begin
              state_d    = S_PAUSE;
              beep_idx_d = '0;
            end else begin
              state_d    = S_GAP;
              beep_idx_d = beep_idx_q + 1'b1;
            end
          end else begin
            state_d = S_BEEP;
          end
        end
      end
      S_SNOOZE: begin
        if (dismiss_rise) begin
          state_d = S_IDLE;
        end else if (phase_done) begin
          state_d    = S_BEEP;
          beep_idx_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Restarting the prescaler on every transition keeps each phase an exact
    // multiple of TICK_DIV cycles, including phases entered mid-tick.
    if (state_d != state_q) begin
      presc_d = '0;
      phase_d = '0;
    end

    buzzer_on_d    = (state_d == S_BEEP);
    no_buzz_d      = (state_d == S_IDLE) || (state_d == S_SNOOZE);
    alarm_active_d = (state_d != S_IDLE);
    snoozed_d      = (state_d == S_SNOOZE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      phase_q        <= '0;
      ring_q         <= '0;
      beep_idx_q     <= '0;
      snooze_cnt_q   <= '0;
      alarm_trig_q   <= 1'b0;
      snooze_req_q   <= 1'b0;
      dismiss_req_q  <= 1'b0;
      buzzer_on_q    <= 1'b0;
      no_buzz_q      <= 1'b1;
      alarm_active_q <= 1'b0;
      snoozed_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      phase_q        <= phase_d;
      ring_q         <= ring_d;
      beep_idx_q     <= beep_idx_d;
      snooze_cnt_q   <= snooze_cnt_d;
      alarm_trig_q   <= alarm_trig_d;
      snooze_req_q   <= snooze_req_d;
      dismiss_req_q  <= dismiss_req_d;
      buzzer_on_q    <= buzzer_on_d;
      no_buzz_q      <= no_buzz_d;
      alarm_active_q <= alarm_active_d;
      snoozed_q      <= snoozed_d;
    end
  end

  assign buzzer_on    = buzzer_on_q;
  assign no_buzz      = no_buzz_q;
  assign alarm_active = alarm_active_q;
  assign snoozed      = snoozed_q;
  assign snooze_cnt   = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_buzz_sequencer.sv
// Testbench for alarm_buzz_sequencer with small timing parameters.
// Output vector layout everywhere: {buzzer_on, no_buzz, alarm_active, snoozed, snooze_cnt[1:0]}.
module tb_alarm_buzz_sequencer;

  localparam int unsigned TD     = 10;
  localparam int unsigned BMS    = 3;
  localparam int unsigned GMS    = 2;
  localparam int unsigned NB     = 2;
  localparam int unsigned PMS    = 5;
  localparam int unsigned SMS    = 20;
  localparam int unsigned MAXS   = 2;
  localparam int unsigned RMS    = 50;
  localparam int unsigned PERIOD = (NB * BMS + (NB - 1) * GMS + PMS) * TD;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarm_trig, snooze_req, dismiss_req;
  logic       buzzer_on, no_buzz, alarm_active, snoozed;
  logic [1:0] snooze_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  alarm_buzz_sequencer #(
    .TICK_DIV       (TD),
    .BEEP_MS        (BMS),
    .GAP_MS         (GMS),
    .BEEPS_PER_BURST(NB),
    .PAUSE_MS       (PMS),
    .SNOOZE_MS      (SMS),
    .MAX_SNOOZES    (MAXS),
    .RING_MS        (RMS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alarm_trig  (alarm_trig),
    .snooze_req  (snooze_req),
    .dismiss_req (dismiss_req),
    .buzzer_on   (buzzer_on),
    .no_buzz     (no_buzz),
    .alarm_active(alarm_active),
    .snoozed     (snoozed),
    .snooze_cnt  (snooze_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus cycles elapsed in that mode. The beep pattern
  // is a fixed function of time since ringing (re)started.
  typedef enum {M_IDLE, M_RING, M_SNOOZE} mmode_t;
  mmode_t      m_mode;
  int unsigned m_el;
  int unsigned m_snz;
  logic        m_pt, m_ps, m_pd;

  function automatic logic in_beep(input int unsigned pos);
    for (int unsigned i = 0; i < NB; i++) begin
      if (pos >= i * (BMS + GMS) * TD && pos < i * (BMS + GMS) * TD + BMS * TD)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [5:0] model_out();
    logic buz;
    buz = (m_mode == M_RING) && in_beep(m_el % PERIOD);
    return {buz, m_mode != M_RING, m_mode != M_IDLE, m_mode == M_SNOOZE, 2'(m_snz)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_el   = 0;
    m_snz  = 0;
    m_pt   = 1'b0;
    m_ps   = 1'b0;
    m_pd   = 1'b0;
  endtask

  task automatic model_edge();
    logic tr, sr, dr;
    tr = alarm_trig & ~m_pt;
    sr = snooze_req & ~m_ps;
    dr = dismiss_req & ~m_pd;
    m_pt = alarm_trig;
    m_ps = snooze_req;
    m_pd = dismiss_req;
    case (m_mode)
      M_IDLE: if (tr) begin m_mode = M_RING; m_el = 0; m_snz = 0; end
      M_RING: begin
        if (dr) m_mode = M_IDLE;
        else if (m_el + 1 == RMS * TD) m_mode = M_IDLE;
        else if (sr && m_snz < MAXS) begin m_mode = M_SNOOZE; m_snz++; m_el = 0; end
        else m_el++;
      end
      default: begin
        if (dr) m_mode = M_IDLE;
        else if (m_el + 1 == SMS * TD) begin m_mode = M_RING; m_el = 0; end
        else m_el++;
      end
    endcase
  endtask

  function automatic logic [5:0] dut_out();
    return {buzzer_on, no_buzz, alarm_active, snoozed, snooze_cnt};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got buz=%b nob=%b act=%b snz=%b cnt=%0d, expected buz=%b nob=%b act=%b snz=%b cnt=%0d",
               name, $time, got[5], got[4], got[3], got[2], got[1:0],
               exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name, dut_out(), model_out());
  endtask

  typedef struct {
    logic        trig, snz, dis;
    int unsigned cycles;
    logic [5:0]  exp;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic t, input logic s, input logic d,
                              input int unsigned c, input logic b, input logic nb,
                              input logic a, input logic sz, input logic [1:0] cnt,
                              input string nm);
    vec_t v;
    v.trig = t; v.snz = s; v.dis = d; v.cycles = c;
    v.exp  = {b, nb, a, sz, cnt};
    v.name = nm;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs applied for 'cycles' edges, then outputs compared to exp
    //                   t  s  d  cyc  buz nob act snz cnt
    tbl.push_back(mk(0, 0, 0,   3, 0, 1, 0, 0, 0, "idle_pre"));
    tbl.push_back(mk(1, 0, 0,   1, 1, 0, 1, 0, 0, "trig_rise"));
    tbl.push_back(mk(1, 0, 0,  29, 1, 0, 1, 0, 0, "beep0_last"));
    tbl.push_back(mk(1, 0, 0,   1, 0, 0, 1, 0, 0, "gap0_first"));
    tbl.push_back(mk(1, 0, 0,  19, 0, 0, 1, 0, 0, "gap0_last"));
    tbl.push_back(mk(1, 0, 0,   1, 1, 0, 1, 0, 0, "beep1_first"));
    tbl.push_back(mk(1, 0, 0,  30, 0, 0, 1, 0, 0, "pause_first"));
    tbl.push_back(mk(1, 0, 0,  49, 0, 0, 1, 0, 0, "pause_last"));
    tbl.push_back(mk(1, 0, 0,   1, 1, 0, 1, 0, 0, "burst2_beep"));
    tbl.push_back(mk(1, 0, 0,  35, 0, 0, 1, 0, 0, "burst2_gap"));
    tbl.push_back(mk(1, 1, 0,   1, 0, 1, 1, 1, 1, "snooze1"));
    tbl.push_back(mk(1, 0, 0, 199, 0, 1, 1, 1, 1, "snooze1_last"));
    tbl.push_back(mk(1, 0, 0,   1, 1, 0, 1, 0, 1, "snooze1_wake"));
    tbl.push_back(mk(1, 0, 0,  29, 1, 0, 1, 0, 1, "wake_beep_last"));
    tbl.push_back(mk(1, 0, 0,   1, 0, 0, 1, 0, 1, "wake_gap"));
    tbl.push_back(mk(1, 1, 0,   1, 0, 1, 1, 1, 2, "snooze2"));
    tbl.push_back(mk(1, 0, 0, 200, 1, 0, 1, 0, 2, "snooze2_wake"));
    tbl.push_back(mk(1, 0, 0,  30, 0, 0, 1, 0, 2, "gap_before_s3"));
    tbl.push_back(mk(1, 1, 0,   1, 0, 0, 1, 0, 2, "snooze3_ignored"));
    tbl.push_back(mk(1, 0, 0,  19, 1, 0, 1, 0, 2, "cadence_kept"));
    tbl.push_back(mk(1, 0, 1,   1, 0, 1, 0, 0, 2, "dismiss_beep"));
    tbl.push_back(mk(1, 0, 0,  50, 0, 1, 0, 0, 2, "held_trig_no_restart"));
    tbl.push_back(mk(0, 0, 0,   1, 0, 1, 0, 0, 2, "trig_low"));
    tbl.push_back(mk(1, 0, 0,   1, 1, 0, 1, 0, 0, "retrigger"));
    tbl.push_back(mk(1, 1, 1,   1, 0, 1, 0, 0, 0, "dismiss_beats_snooze"));
    tbl.push_back(mk(0, 0, 0,   1, 0, 1, 0, 0, 0, "idle_gap"));
    tbl.push_back(mk(1, 0, 0,   1, 1, 0, 1, 0, 0, "timeout_start"));
    tbl.push_back(mk(1, 0, 0, 498, 0, 0, 1, 0, 0, "ring_498"));
    tbl.push_back(mk(1, 0, 0,   1, 0, 0, 1, 0, 0, "ring_499"));
    tbl.push_back(mk(1, 1, 0,   1, 0, 1, 0, 0, 0, "timeout_beats_snooze"));
    tbl.push_back(mk(0, 0, 0,   1, 0, 1, 0, 0, 0, "idle_gap2"));
    tbl.push_back(mk(1, 0, 0,   1, 1, 0, 1, 0, 0, "start3"));
    tbl.push_back(mk(1, 0, 0,  99, 0, 0, 1, 0, 0, "ring_99"));
    tbl.push_back(mk(1, 1, 0,   1, 0, 1, 1, 1, 1, "snooze_mid"));
    tbl.push_back(mk(1, 0, 0, 200, 1, 0, 1, 0, 1, "wake3"));
    tbl.push_back(mk(1, 0, 0, 499, 0, 0, 1, 0, 1, "ring_restart_499"));
    tbl.push_back(mk(1, 0, 0,   1, 0, 1, 0, 0, 1, "timeout_after_snooze"));

    rst = 1'b1;
    alarm_trig = 1'b0;
    snooze_req = 1'b0;
    dismiss_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_out(), 6'b010000);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      alarm_trig  = tbl[i].trig;
      snooze_req  = tbl[i].snz;
      dismiss_req = tbl[i].dis;
      repeat (tbl[i].cycles) step(tbl[i].name);
      check(tbl[i].name, dut_out(), tbl[i].exp);
    end

    // Asynchronous reset mid-BEEP with the trigger held through release.
    alarm_trig = 1'b0;
    step("rst_pre_low");
    alarm_trig = 1'b1;
    repeat (5) step("rst_pre_beep");
    check("rst_pre_beep_state", dut_out(), 6'b101000);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", dut_out(), 6'b010000);
    model_reset();
    #3;
    rst = 1'b0;
    step("rst_release");
    check("rst_one_event", dut_out(), 6'b101000);
    repeat (300) step("rst_held_trig");

    // Random level changes on all three inputs against the model.
    for (int unsigned i = 0; i < 4000; i++) begin
      if ($urandom_range(59, 0) == 0) alarm_trig = ~alarm_trig;
      if ($urandom_range(79, 0) == 0) snooze_req = ~snooze_req;
      if ($urandom_range(((i < 2000) ? 499 : 99), 0) == 0) dismiss_req = ~dismiss_req;
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_buzz_sequencer.md
Name: alarm_buzz_sequencer

Overview:
- Upstream driver of the 440 Hz tone stage. Turns an alarm trigger plus snooze/dismiss requests into the `buzzer_on` / `NoBuzz` levels that tone stage consumes.
- Beep cadence: bursts of short beeps separated by gaps, a longer pause between bursts, repeated until dismissed, snoozed or timed out.
- All timing is derived from an internal 1 ms tick prescaled from the 100 MHz `clk`.

Parameters:
- TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz).
- BEEP_MS, 100, ticks buzzer is on per beep.
- GAP_MS, 100, ticks off between beeps within a burst.
- BEEPS_PER_BURST, 4, beeps per burst (>=1).
- PAUSE_MS, 600, ticks off after the last beep of a burst.
- SNOOZE_MS, 300000, ticks of silence per snooze.
- MAX_SNOOZES, 3, snoozes honoured per alarm event; further snooze requests are ignored.
- RING_MS, 120000, ticks of cumulative ringing before auto-dismiss.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- alarm_trig  in  1  synchronous level from alarm compare; a rising edge starts an alarm event.
- snooze_req  in  1  synchronous, debounced; rising edge = one request.
- dismiss_req  in  1  synchronous, debounced; rising edge = one request.
- buzzer_on  out  1  registered; high exactly while in BEEP.
- no_buzz  out  1  registered; high in IDLE and SNOOZE.
- alarm_active  out  1  registered; high in any state except IDLE.
- snoozed  out  1  registered; high in SNOOZE.
- snooze_cnt  out  2  snoozes used in the current event (saturating, width covers MAX_SNOOZES).

Behaviour:
- Reset (async, any time, including mid-alarm):
  - state=IDLE; all counters and edge-detect flops = 0.
  - buzzer_on=0, no_buzz=1, alarm_active=0, snoozed=0, snooze_cnt=0.
- Edge detect: each input is registered; rise = in & ~in_q. A held level never re-fires. Reset clears in_q to 0, so a trigger held high through reset release fires once.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 on the cycle its count equals TICK_DIV-1.
  - Cleared on every state transition, so each phase lasts exactly N*TICK_DIV cycles.
  - phase_cnt counts ticks and is cleared on each transition.
- States: IDLE, BEEP, GAP, PAUSE, SNOOZE.
- Transitions, evaluated per clk with priority dismiss > timeout > snooze > phase expiry:
  - IDLE: trig rise -> BEEP; beep_idx=0, ring_cnt=0, snooze_cnt=0. Snooze/dismiss in IDLE are ignored.
  - BEEP: on the tick where phase_cnt reaches BEEP_MS-1:
    - if beep_idx==BEEPS_PER_BURST-1 -> PAUSE, beep_idx=0;
    - else -> GAP, beep_idx+1.
  - GAP: after GAP_MS ticks -> BEEP.
  - PAUSE: after PAUSE_MS ticks -> BEEP.
  - Any of BEEP/GAP/PAUSE:
    - dismiss rise -> IDLE.
    - ring_cnt reaching RING_MS-1 on a tick -> IDLE (auto-dismiss).
    - snooze rise with snooze_cnt<MAX_SNOOZES -> SNOOZE, snooze_cnt+1, ring_cnt=0.
    - snooze rise with snooze_cnt==MAX_SNOOZES -> ignored, ringing continues.
  - SNOOZE:
    - after SNOOZE_MS ticks -> BEEP with beep_idx=0 (fresh burst).
    - dismiss rise -> IDLE.
    - snooze rise -> ignored.
- ring_cnt: increments on each tick in BEEP/GAP/PAUSE; holds in SNOOZE.
- trig rise outside IDLE: ignored (no restart).
- Outputs:
  - Registered Moore decode of next state, so outputs change on the same edge as the state.
  - Latency: trig rise sampled at edge k -> buzzer_on=1 after edge k.
  - Dismiss sampled at edge k -> buzzer_on=0 and no_buzz=1 after edge k.
- Simultaneous dismiss+snooze -> IDLE. Timeout on the same cycle as snooze -> IDLE.
- Counter widths: $clog2 of the largest compare value, plus 1 bit. No wrap is possible before the compare fires.

Test Plan (TICK_DIV=10, BEEP_MS=3, GAP_MS=2, BEEPS_PER_BURST=2, PAUSE_MS=5, SNOOZE_MS=20, MAX_SNOOZES=2, RING_MS=50):
- Cadence: trig rises at edge k ->
  - buzzer_on high 30 cycles, low 20, high 30, low 50, then repeats;
  - no_buzz=0 and alarm_active=1 throughout.
- Dismiss mid-BEEP -> next edge: buzzer_on=0, no_buzz=1, alarm_active=0. Holding trig high afterwards does not restart; a new trig rise does.
- Snooze: snooze pulse in GAP -> snoozed=1 for 200 cycles, snooze_cnt=1, then buzzer_on high 30 cycles. A third snooze after two are used is ignored and buzzer_on keeps cadence.
- Timeout: no inputs after trig -> after 500 cycles of ringing, state=IDLE and no_buzz=1. With one snooze in between, the ring count restarts and the total ringing is again 500 cycles after the snooze.
- Priority: dismiss and snooze rise on the same edge in BEEP -> IDLE, snooze_cnt not incremented into SNOOZE.
- Reset: assert rst asynchronously mid-BEEP, between clk edges -> buzzer_on=0 and no_buzz=1 immediately; after release with trig held high, exactly one new event starts.
